// File: rtl/pipelined_ctrl_unit.sv
// RV32I(+M) control path: decodes the D-stage instruction and carries the control bundle
// through the E, M and W pipeline registers, holding E while a multicycle divide runs.
module pipelined_ctrl_unit #(
    parameter int unsigned EN_MEXT     = 1,
    parameter int unsigned DIV_LATENCY = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct75,
    input  logic       Funct70,
    input  logic       FlushE,
    output logic [2:0] ImmSrcD,
    output logic       StallReq,
    output logic       MdStart,
    output logic       RegWriteE,
    output logic       ALUSrcE,
    output logic       BranchE,
    output logic       JumpE,
    output logic       PCResultSrcE,
    output logic       MulDivE,
    output logic       IllegalE,
    output logic [3:0] ALUControlE,
    output logic [2:0] Funct3E,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic [2:0] ResultSrcM,
    output logic [2:0] Funct3M,
    output logic       RegWriteW,
    output logic [2:0] ResultSrcW
);

    localparam int unsigned CntW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DIV_LATENCY - 1);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       pc_result_src;
        logic       mul_div;
        logic       illegal;
        logic [3:0] alu_control;
        logic [2:0] funct3;
        logic [2:0] result_src;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [2:0] result_src;
        logic [2:0] funct3;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] result_src;
    } ctrl_w_t;

    ctrl_e_t       dec;
    logic [1:0]    alu_op;
    logic          dec_is_div;
    ctrl_e_t       e_d, e_q;
    ctrl_m_t       m_d, m_q;
    ctrl_w_t       w_d, w_q;
    logic [CntW-1:0] md_cnt_d, md_cnt_q;
    logic          md_start_d, md_start_q;
    logic          md_busy;

    always_comb begin
        dec        = '0;
        dec.funct3 = Funct3;
        ImmSrcD    = 3'd0;
        alu_op     = 2'b00;
        case (Opcode)
            OpLoad: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 3'd1;
            end
            OpStore: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                ImmSrcD       = 3'd1;
            end
            OpR: begin
                dec.reg_write = 1'b1;
                alu_op        = 2'b10;
                if ((EN_MEXT != 0) && Funct70) begin
                    dec.mul_div    = 1'b1;
                    dec.result_src = 3'd5;
                end
            end
            OpI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                alu_op        = 2'b10;
            end
            OpBr: begin
                dec.branch = 1'b1;
                ImmSrcD    = 3'd2;
                alu_op     = 2'b01;
            end
            OpJal: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                ImmSrcD        = 3'd3;
                dec.result_src = 3'd2;
            end
            OpJalr: begin
                dec.reg_write     = 1'b1;
                dec.jump          = 1'b1;
                dec.alu_src       = 1'b1;
                dec.result_src    = 3'd2;
                dec.pc_result_src = 1'b1;
            end
            OpLui: begin
                dec.reg_write  = 1'b1;
                ImmSrcD        = 3'd4;
                dec.result_src = 3'd3;
            end
            OpAuipc: begin
                dec.reg_write  = 1'b1;
                ImmSrcD        = 3'd4;
                dec.result_src = 3'd4;
            end
            default: dec.illegal = 1'b1;
        endcase

        case (alu_op)
            2'b00: dec.alu_control = AluAdd;
            2'b01: dec.alu_control = AluSub;
            default: begin
                case (Funct3)
                    3'b000:  dec.alu_control = (Opcode[5] & Funct75) ? AluSub : AluAdd;
                    3'b001:  dec.alu_control = AluSll;
                    3'b010:  dec.alu_control = AluSlt;
                    3'b011:  dec.alu_control = AluSltu;
                    3'b100:  dec.alu_control = AluXor;
                    3'b101:  dec.alu_control = Funct75 ? AluSra : AluSrl;
                    3'b110:  dec.alu_control = AluOr;
                    default: dec.alu_control = AluAnd;
                endcase
            end
        endcase
    end

    assign dec_is_div = dec.mul_div & Funct3[2];
    assign md_busy    = (md_cnt_q != '0);

    // A flush aborts an in-flight divide and takes priority over the stall hold.
    always_comb begin
        e_d        = e_q;
        md_cnt_d   = md_cnt_q;
        md_start_d = 1'b0;
        if (FlushE) begin
            e_d      = '0;
            md_cnt_d = '0;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CntW'(1);
        end else begin
            e_d        = dec;
            md_cnt_d   = dec_is_div ? CntLoad : '0;
            md_start_d = dec_is_div;
        end
    end

    always_comb begin
        m_d = '0;
        if (!md_busy) begin
            m_d.reg_write  = e_q.reg_write;
            m_d.mem_write  = e_q.mem_write;
            m_d.result_src = e_q.result_src;
            m_d.funct3     = e_q.funct3;
        end
        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
            md_cnt_q   <= '0;
            md_start_q <= 1'b0;
        end else begin
            e_q        <= e_d;
            m_q        <= m_d;
            w_q        <= w_d;
            md_cnt_q   <= md_cnt_d;
            md_start_q <= md_start_d;
        end
    end

    assign StallReq     = md_busy;
    assign MdStart      = md_start_q;
    assign RegWriteE    = e_q.reg_write;
    assign ALUSrcE      = e_q.alu_src;
    assign BranchE      = e_q.branch;
    assign JumpE        = e_q.jump;
    assign PCResultSrcE = e_q.pc_result_src;
    assign MulDivE      = e_q.mul_div;
    assign IllegalE     = e_q.illegal;
    assign ALUControlE  = e_q.alu_control;
    assign Funct3E      = e_q.funct3;
    assign RegWriteM    = m_q.reg_write;
    assign MemWriteM    = m_q.mem_write;
    assign ResultSrcM   = m_q.result_src;
    assign Funct3M      = m_q.funct3;
    assign RegWriteW    = w_q.reg_write;
    assign ResultSrcW   = w_q.result_src;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Scoreboard bench for pipelined_ctrl_unit: an instruction-level reference model predicts
// each cycle's outputs; a separate monitor compares them on the falling edge.
module tb_pipelined_ctrl_unit;

    localparam int unsigned EnMext = 1;
    localparam int unsigned DivLat = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = 7'b0010011;
    logic [2:0] Funct3 = 3'd0;
    logic       Funct75 = 1'b0;
    logic       Funct70 = 1'b0;
    logic       FlushE = 1'b0;
    logic [2:0] ImmSrcD;
    logic       StallReq, MdStart;
    logic       RegWriteE, ALUSrcE, BranchE, JumpE, PCResultSrcE, MulDivE, IllegalE;
    logic [3:0] ALUControlE;
    logic [2:0] Funct3E;
    logic       RegWriteM, MemWriteM;
    logic [2:0] ResultSrcM, Funct3M;
    logic       RegWriteW;
    logic [2:0] ResultSrcW;

    always #5 clk = ~clk;

    pipelined_ctrl_unit #(.EN_MEXT(EnMext), .DIV_LATENCY(DivLat)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3), .Funct75(Funct75),
        .Funct70(Funct70), .FlushE(FlushE), .ImmSrcD(ImmSrcD), .StallReq(StallReq),
        .MdStart(MdStart), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
        .JumpE(JumpE), .PCResultSrcE(PCResultSrcE), .MulDivE(MulDivE), .IllegalE(IllegalE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    typedef struct packed {
        logic       rw, mw, alusrc, br, jmp, pcrs, md, ill;
        logic [3:0] aluc;
        logic [2:0] f3, rs, imm;
    } instr_t;

    typedef struct packed {
        logic [2:0] imm;
        logic       stall, start;
        instr_t     e, m, w;
    } snap_t;

    snap_t  exp_q[$];
    instr_t me, mm, mw;
    int     rem = 0;
    bit     start = 1'b0;
    bit     mvalid = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f75, input bit is_reg);
        case (f3)
            3'd0: return (is_reg && f75) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f75 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic instr_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f75, input logic f70);
        instr_t r = '0;
        r.f3 = f3;
        case (op)
            7'b0000011: begin r.rw = 1; r.alusrc = 1; r.rs = 3'd1; end
            7'b0100011: begin r.mw = 1; r.alusrc = 1; r.imm = 3'd1; end
            7'b0110011: begin
                r.rw = 1;
                if (EnMext != 0 && f70) begin r.md = 1; r.rs = 3'd5; end
                else r.aluc = alu_fn(f3, f75, 1'b1);
            end
            7'b0010011: begin r.rw = 1; r.alusrc = 1; r.aluc = alu_fn(f3, f75, 1'b0); end
            7'b1100011: begin r.br = 1; r.imm = 3'd2; r.aluc = 4'd1; end
            7'b1101111: begin r.rw = 1; r.jmp = 1; r.imm = 3'd3; r.rs = 3'd2; end
            7'b1100111: begin r.rw = 1; r.jmp = 1; r.alusrc = 1; r.rs = 3'd2; r.pcrs = 1; end
            7'b0110111: begin r.rw = 1; r.imm = 3'd4; r.rs = 3'd3; end
            7'b0010111: begin r.rw = 1; r.imm = 3'd4; r.rs = 3'd4; end
            default: r.ill = 1;
        endcase
        return r;
    endfunction

    // Instruction-level view: a divide sits in E for DivLat cycles, M sees bubbles meanwhile.
    task automatic model_edge(input bit rst, input bit flush, input instr_t d);
        bit busy;
        if (rst) begin
            me = '0; mm = '0; mw = '0; rem = 0; start = 0;
        end else begin
            busy = (rem > 0);
            mw = mm;
            mm = busy ? '0 : me;
            if (flush) begin
                me = '0; rem = 0; start = 0;
            end else if (busy) begin
                rem = rem - 1; start = 0;
            end else begin
                me = d;
                start = d.md && d.f3[2];
                rem = start ? int'(DivLat) - 1 : 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit flush, input logic [6:0] op,
                        input logic [2:0] f3, input logic f75, input logic f70);
        instr_t d;
        snap_t  s;
        reset = rst; FlushE = flush; Opcode = op; Funct3 = f3; Funct75 = f75; Funct70 = f70;
        d = ref_decode(op, f3, f75, f70);
        if (mvalid) begin
            s.imm = d.imm; s.stall = (rem > 0); s.start = start;
            s.e = me; s.m = mm; s.w = mw;
            exp_q.push_back(s);
        end
        @(posedge clk);
        #1;
        model_edge(rst, flush, d);
        if (rst) mvalid = 1'b1;
    endtask

    task automatic nop();
        step(0, 0, 7'b0010011, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        snap_t s;
        logic [3:0] ac, ec;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                ac = s.e.md ? 4'd0 : ALUControlE;
                ec = s.e.md ? 4'd0 : s.e.aluc;
                check("d_ctrl", {ImmSrcD, StallReq, MdStart}, {s.imm, s.stall, s.start});
                check("e_stage", {RegWriteE, ALUSrcE, BranchE, JumpE, PCResultSrcE, MulDivE,
                                  IllegalE, ac, Funct3E},
                      {s.e.rw, s.e.alusrc, s.e.br, s.e.jmp, s.e.pcrs, s.e.md, s.e.ill, ec,
                       s.e.f3});
                check("m_stage", {RegWriteM, MemWriteM, ResultSrcM, Funct3M},
                      {s.m.rw, s.m.mw, s.m.rs, s.m.f3});
                check("w_stage", {RegWriteW, ResultSrcW}, {s.w.rw, s.w.rs});
            end
        end
    end

    initial begin : stimulus
        logic [6:0] ops [10];
        int n, starts, m_at;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};

        step(1, 0, 7'b0010011, 3'd0, 0, 0);
        step(1, 0, 7'b0010011, 3'd0, 0, 0);
        check("reset_e", {RegWriteE, MulDivE, IllegalE, ALUControlE, StallReq, MdStart}, '0);

        step(0, 0, 7'b0110011, 3'd0, 0, 0);           // add
        check("add_e", {RegWriteE, ALUControlE}, 5'b1_0000);
        nop(); nop();
        check("add_w", RegWriteW, 1);

        step(0, 0, 7'b0110011, 3'd0, 1, 0);           // sub
        check("sub_aluc", ALUControlE, 4'd1);
        step(0, 0, 7'b0110011, 3'd5, 1, 0);           // sra
        check("sra_aluc", ALUControlE, 4'd9);
        step(0, 0, 7'b0010011, 3'd5, 1, 0);           // srai
        check("srai_aluc", ALUControlE, 4'd9);
        step(0, 0, 7'b0000011, 3'd2, 0, 0);           // lw
        step(0, 0, 7'b0100011, 3'd2, 0, 0);           // sw
        step(0, 0, 7'b1100011, 3'd0, 0, 0);           // beq
        step(0, 0, 7'b1100111, 3'd0, 0, 0);           // jalr
        step(0, 0, 7'b0110111, 3'd0, 0, 0);           // lui
        step(0, 0, 7'b0010111, 3'd0, 0, 0);           // auipc
        nop(); nop(); nop();

        step(0, 0, 7'b0110011, 3'b100, 0, 1);         // div
        n = 0; starts = int'(MdStart); m_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (StallReq) n++;
            nop();
            if (MdStart) starts++;
            if (m_at < 0 && RegWriteM && ResultSrcM == 3'd5) m_at = i;
        end
        check("div_stall_cycles", n, DivLat - 1);
        check("div_mdstart_pulses", starts, 1);
        check("div_m_arrival", m_at, DivLat - 1);

        step(0, 0, 7'b0110011, 3'b101, 0, 1);         // divu then rem back to back
        for (int i = 0; i < int'(DivLat) - 1; i++) step(0, 0, 7'b0110011, 3'b110, 0, 1);
        for (int i = 0; i < 12; i++) nop();

        step(0, 0, 7'b0110011, 3'b000, 0, 1);         // mul
        check("mul_no_stall", {StallReq, MulDivE}, 2'b01);
        nop(); nop();

        step(0, 0, 7'b0110011, 3'b100, 0, 1);         // div, flushed on its third cycle
        nop(); nop();
        step(0, 1, 7'b0010011, 3'd0, 0, 0);
        check("flush_clear", {StallReq, MulDivE, RegWriteE}, 3'b000);
        for (int i = 0; i < 4; i++) nop();

        step(0, 0, 7'b0110011, 3'b111, 0, 1);         // remu, then reset mid-op
        nop();
        step(1, 0, 7'b0010011, 3'd0, 0, 0);
        check("reset_mid_div", {StallReq, MdStart, RegWriteE, MulDivE, RegWriteM, RegWriteW,
                                ResultSrcM, ResultSrcW}, '0);
        step(0, 0, 7'b1111111, 3'd0, 0, 0);           // illegal
        check("illegal_e", {IllegalE, RegWriteE}, 2'b10);
        nop(); nop();
        check("illegal_no_mem", MemWriteM, 0);

        for (int i = 0; i < 3000; i++) begin
            int unsigned k;
            logic [6:0] op;
            k  = $urandom_range(0, 10);
            op = (k == 10) ? 7'($urandom) : ops[k];
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), op,
                 3'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 12; i++) nop();
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
